wb_retire_sched: RTL
====================

# wb_retire_sched

Dual-issue retire scheduler between the WB stage and the single-record debug trace port. Each cycle it captures up to two retiring register-file write records (lane 1 older than lane 2) into a small in-order buffer. It drains the buffer one record per cycle onto `debug_wb_*`, and raises a pipeline stall request before the buffer can overflow. This gives a clean, clock-edge-only trace stream with no dual-edge tricks, in strict program order.

## Interface
Parameters:
- DEPTH, 8, buffer entries; power of two, ≥ 4.

Ports:
- clk  in  1  system clock; all state on posedge.
- resetn  in  1  asynchronous, active-low reset.
- i1_valid  in  1  lane 1 (older) retires this cycle.
- i1_pc  in  32  lane 1 PC.
- i1_we  in  1  lane 1 regfile write enable.
- i1_waddr  in  5  lane 1 destination register.
- i1_wdata  in  32  lane 1 write data.
- i2_valid / i2_pc / i2_we / i2_waddr / i2_wdata  in  1/32/1/5/32  lane 2 (younger), same meaning.
- stall_req  out  1  registered; request to freeze WB input (drives stall bit 5 source).
- debug_wb_pc  out  32  PC of record on trace port.
- debug_wb_rf_wen  out  4  {4{we}} of record; 0 when no record.
- debug_wb_rf_wnum  out  5  destination of record.
- debug_wb_rf_wdata  out  32  data of record.
- overflow_err  out  1  sticky; push attempted while full.

## Operation
- Record = {pc, we, waddr, wdata}, 70 bits.
- Push: at each posedge, valid lanes are written in order: lane 1 at wr_ptr, lane 2 at wr_ptr+1 if both are valid, otherwise at wr_ptr. Only lane 2 valid → pushed alone. wr_ptr advances by the number pushed (0/1/2), mod DEPTH.
- Pop: at each posedge, if the pre-edge count > 0, the head record loads into the debug registers and rd_ptr advances by 1 mod DEPTH.
- Empty: if the pre-edge count is 0, debug_wb_rf_wen, wnum and wdata load 0, and debug_wb_pc holds its previous value.
- No bypass. A record is never popped in the edge that writes it.
- count_next = count + pushes − pop. count width is clog2(DEPTH+1).
- stall_req is registered: stall_req ← (count_next > DEPTH−4), i.e. fewer than 4 free slots after the edge.
- Upstream contract: in the first cycle stall_req is high, lanes may still carry up to 2 valid records. From the second high cycle until stall_req falls, both valids are 0 (WB inserts bubbles).
- Threshold guarantee: the contract above can never overflow a DEPTH ≥ 4 buffer.
- Overflow (contract violation): a push that would exceed DEPTH drops the excess lane(s), in lane order, and sets overflow_err. overflow_err clears only on reset.
- No flush input. Retired instructions are architecturally committed and are always traced.

## Timing
- Reset (resetn low, async): pointers = 0, count = 0, stall_req = 0, overflow_err = 0, and all debug_wb_* = 0. Takes effect immediately, independent of clk, including mid-drain. Buffered records are discarded.
- Latency: lane 1 presented in cycle n is written at edge n+1 and appears on the trace in cycle n+2 (if the buffer was empty). Lane 2 of the same cycle appears in cycle n+3.
- Throughput: 1 record/cycle out. Sustained dual retire grows count by 1 per cycle until stall_req.
- stall_req falls the cycle after count_next ≤ DEPTH−4.
- Wrap-around: pointers wrap mod DEPTH with no bubble. A two-lane push straddling the last entry writes entry DEPTH−1 and entry 0.
- Simultaneous push and pop at count = DEPTH−1 is legal. count_next is computed with the pop included.

## Structure
- In `lib/defines.vh`: `RETIRE_REC_WD` (70) and record field offsets.
- Sub-module `retire_fifo`: 2-write/1-read circular buffer with DEPTH, storage, pointers, count and a full-drop flag.
- Top module: lane packing, stall_req register, debug output registers.

## Test plan
- Reset mid-drain: buffer holds 3 records; assert resetn low between edges → all outputs 0 immediately, and no records appear after release.
- Single lane: i1 {pc 0xBFC00000, we 1, waddr 2, wdata 0x1234} in cycle 0 → cycle 2 trace shows that record with wen 4'hF. Cycle 3 shows wen 0 and pc still 0xBFC00000.
- Dual lane order: cycle 0, i1 pc 0x100 and i2 pc 0x104 → trace pc 0x100 in cycle 2 and 0x104 in cycle 3. Lane-2-only push → that lane's record appears alone.
- Stall threshold (DEPTH 8): dual valid every cycle → stall_req rises when count reaches 5. Honoring the contract, count peaks ≤ 6. No overflow_err, and all records drain in order.
- Wrap-around: push so that wr_ptr = 7 with a two-lane push → entries 7 and 0 are written. Trace order stays correct across the wrap.
- Contract violation: hold both valids while stall_req is high → overflow_err sets when full, excess lane 2 is dropped, and the flag stays set until reset.

Source files
------------

// File: rtl/wb_retire_sched_pkg.sv
// wb_retire_sched_pkg: shared types for the WB retire scheduler.
//   retire_rec_t  - one retired regfile write record {pc, we, waddr, wdata}
//   RETIRE_REC_WD - packed width of a record (70 bits)
package wb_retire_sched_pkg;

    localparam int RETIRE_REC_WD = 70;

    // Field layout, MSB first: pc[69:38], we[37], waddr[36:32], wdata[31:0]
    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } retire_rec_t;

endpackage

// File: rtl/wb_retire_sched_if.sv
// wb_retire_sched_if: bundle of the two WB retire lanes, the stall request
// back to the pipeline and the single-record debug trace port.
//   master - WB stage / trace consumer side (drives lanes)
//   slave  - the retire scheduler (drives stall, trace, overflow flag)
interface wb_retire_sched_if;
    logic        i1_valid;
    logic [31:0] i1_pc;
    logic        i1_we;
    logic [4:0]  i1_waddr;
    logic [31:0] i1_wdata;
    logic        i2_valid;
    logic [31:0] i2_pc;
    logic        i2_we;
    logic [4:0]  i2_waddr;
    logic [31:0] i2_wdata;
    logic        stall_req;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        overflow_err;

    modport master (
        output i1_valid, i1_pc, i1_we, i1_waddr, i1_wdata,
        output i2_valid, i2_pc, i2_we, i2_waddr, i2_wdata,
        input  stall_req, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
        input  debug_wb_rf_wdata, overflow_err
    );

    modport slave (
        input  i1_valid, i1_pc, i1_we, i1_waddr, i1_wdata,
        input  i2_valid, i2_pc, i2_we, i2_waddr, i2_wdata,
        output stall_req, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
        output debug_wb_rf_wdata, overflow_err
    );
endinterface

// File: rtl/wb_retire_sched_retire_fifo.sv
// retire_fifo: 2-write / 1-read circular record buffer.
//   push_a/_valid - first record of this cycle (older)
//   push_b/_valid - second record, only meaningful when push_a_valid is set
//   pop, head     - pop is high whenever the buffer is non-empty; head is
//                   the record leaving at this edge
//   count_next    - occupancy after this edge (pushes and pop included)
//   drop          - a record was refused this edge because the buffer is full
module retire_fifo
    import wb_retire_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push_a_valid,
    input  retire_rec_t                  push_a,
    input  logic                         push_b_valid,
    input  retire_rec_t                  push_b,
    output logic                         pop,
    output retire_rec_t                  head,
    output logic [$clog2(DEPTH+1)-1:0]   count_next,
    output logic                         drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [RETIRE_REC_WD-1:0] mem_q [DEPTH];
    logic [RETIRE_REC_WD-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, room, n_req, n_acc;

    always_comb begin
        pop       = (count_q != '0);
        head      = retire_rec_t'(mem_q[rd_ptr_q]);
        // The popped slot is free again at this same edge, so it counts as room.
        room      = CW'(DEPTH) - count_q + CW'(pop);
        n_req     = CW'(push_a_valid) + CW'(push_b_valid);
        drop      = (n_req > room);
        n_acc     = drop ? room : n_req;
        wr_ptr_nx = wr_ptr_q + PW'(1);
        mem_d     = mem_q;
        // Lane order is preserved on a drop: push_a is taken before push_b.
        if (n_acc != '0)     mem_d[wr_ptr_q]  = push_a;
        if (n_acc == CW'(2)) mem_d[wr_ptr_nx] = push_b;
        wr_ptr_d   = wr_ptr_q + PW'(n_acc);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + n_acc - CW'(pop);
        count_next = count_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/wb_retire_sched.sv
// wb_retire_sched: dual-issue retire scheduler feeding a single-record trace.
//   clk, resetn - clock, async active-low reset
//   bus (slave) - lanes i1 (older) / i2 (younger) in; stall_req, debug_wb_*
//                 and sticky overflow_err out (all registered)
// Up to two records are buffered per cycle and drained one per cycle in
// program order. stall_req rises once fewer than 4 slots remain free.
module wb_retire_sched
    import wb_retire_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                resetn,
    wb_retire_sched_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);

    retire_rec_t   rec1, rec2, push_a, head;
    logic          push_a_valid, push_b_valid, pop, drop;
    logic [CW-1:0] count_next;

    logic [31:0] dbg_pc_q, dbg_pc_d, dbg_wdata_q, dbg_wdata_d;
    logic [3:0]  dbg_wen_q, dbg_wen_d;
    logic [4:0]  dbg_wnum_q, dbg_wnum_d;
    logic        stall_q, stall_d, ovf_q, ovf_d;

    // A lone lane 2 takes the first slot, so the buffer never holds a gap.
    always_comb begin
        rec1         = '{pc: bus.i1_pc, we: bus.i1_we, waddr: bus.i1_waddr, wdata: bus.i1_wdata};
        rec2         = '{pc: bus.i2_pc, we: bus.i2_we, waddr: bus.i2_waddr, wdata: bus.i2_wdata};
        push_a_valid = bus.i1_valid | bus.i2_valid;
        push_a       = bus.i1_valid ? rec1 : rec2;
        push_b_valid = bus.i1_valid & bus.i2_valid;
    end

    retire_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_a_valid (push_a_valid),
        .push_a       (push_a),
        .push_b_valid (push_b_valid),
        .push_b       (rec2),
        .pop          (pop),
        .head         (head),
        .count_next   (count_next),
        .drop         (drop)
    );

    always_comb begin
        // Idle cycle: no write reported, PC keeps the last traced value.
        dbg_pc_d    = dbg_pc_q;
        dbg_wen_d   = '0;
        dbg_wnum_d  = '0;
        dbg_wdata_d = '0;
        if (pop) begin
            dbg_pc_d    = head.pc;
            dbg_wen_d   = {4{head.we}};
            dbg_wnum_d  = head.waddr;
            dbg_wdata_d = head.wdata;
        end
        stall_d = (count_next > CW'(DEPTH - 4));
        ovf_d   = ovf_q | drop;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dbg_pc_q    <= '0;
            dbg_wen_q   <= '0;
            dbg_wnum_q  <= '0;
            dbg_wdata_q <= '0;
            stall_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            dbg_pc_q    <= dbg_pc_d;
            dbg_wen_q   <= dbg_wen_d;
            dbg_wnum_q  <= dbg_wnum_d;
            dbg_wdata_q <= dbg_wdata_d;
            stall_q     <= stall_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.stall_req         = stall_q;
    assign bus.debug_wb_pc       = dbg_pc_q;
    assign bus.debug_wb_rf_wen   = dbg_wen_q;
    assign bus.debug_wb_rf_wnum  = dbg_wnum_q;
    assign bus.debug_wb_rf_wdata = dbg_wdata_q;
    assign bus.overflow_err      = ovf_q;
endmodule
